// File: rtl/irq_priority_encoder_if.sv
// Request/mask inputs and code/valid/ack handshake of the IRQ priority encoder.
// The master side drives requests and acks; the slave side presents codes.
interface irq_priority_encoder_if #(
   parameter int N = 8,
   parameter int W = 3
);

   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         ack;
   logic         ovr_clr;
   logic [W-1:0] code;
   logic         valid;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   modport master (
      output req,
      output mask,
      output ack,
      output ovr_clr,
      input  code,
      input  valid,
      input  pending,
      input  overrun
   );

   modport slave (
      input  req,
      input  mask,
      input  ack,
      input  ovr_clr,
      output code,
      output valid,
      output pending,
      output overrun
   );

endinterface

// File: rtl/irq_priority_encoder.sv
// Sequential 8-to-3 priority encoder: latches request pulses into a pending register and
// presents the highest unmasked pending index through a valid/ack handshake, one at a time.
module irq_priority_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input logic                  clk,
   input logic                  rst,
   irq_priority_encoder_if.slave bus
);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [W-1:0] code_q;
   logic [W-1:0] code_d;
   logic [N-1:0] pending_q;
   logic [N-1:0] pending_d;
   logic [N-1:0] overrun_q;
   logic [N-1:0] overrun_d;

   logic         fire;
   logic [N-1:0] clrVec;
   logic [N-1:0] ovrEvent;
   logic [N-1:0] candVec;

   // Highest set bit wins; a later (higher) index overwrites a lower one.
   function automatic logic [W-1:0] msbIndex(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            idx = i[W-1:0];
         end
      end
      return idx;
   endfunction

   always_comb begin
      fire      = (state_q == PRESENT) && bus.ack;
      clrVec    = '0;
      if (fire) begin
         clrVec[code_q] = 1'b1;
      end

      pending_d = (pending_q & ~clrVec) | bus.req;
      ovrEvent  = bus.req & pending_q & ~clrVec;
      overrun_d = bus.ovr_clr ? ovrEvent : (overrun_q | ovrEvent);

      // Selection works from the registered pending bits, so a request takes two edges to reach valid.
      candVec   = pending_q & ~bus.mask;
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (candVec != '0) begin
               state_d = PRESENT;
               code_d  = msbIndex(candVec);
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         code_q    <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.code    = code_q;
   assign bus.valid   = (state_q == PRESENT);
   assign bus.pending = pending_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed, self-checking bench for irq_priority_encoder; each task covers one scenario.
module tb_irq_priority_encoder;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   irq_priority_encoder_if #(.N(8), .W(3)) bus ();

   irq_priority_encoder #(.N(8), .W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1ns after the rising edge, inputs are changed right after sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst         = 1'b1;
      bus.req     = '0;
      bus.mask    = '0;
      bus.ack     = 1'b0;
      bus.ovr_clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.req     = 8'hFF;
      bus.mask    = '0;
      bus.ack     = 1'b0;
      bus.ovr_clr = 1'b0;
      step();
      step();
      rst     = 1'b0;
      bus.req = '0;
      step();
      testsRun++;
      if (bus.pending !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_pending: got %h expected 00", bus.pending);
      end
      testsRun++;
      if (bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid);
      end
      testsRun++;
      if (bus.code !== 3'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_code: got %0d expected 0", bus.code);
      end
      testsRun++;
      if (bus.overrun !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_overrun: got %h expected 00", bus.overrun);
      end
   endtask

   task automatic test_single_request();
      doReset();
      bus.req = 8'b0000_0100;
      step();
      bus.req = '0;
      testsRun++;
      if (bus.pending !== 8'h04 || bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_latch: pending %h valid %b expected 04 0", bus.pending, bus.valid);
      end
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL single_present: valid %b code %0d expected 1 2", bus.valid, bus.code);
      end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      testsRun++;
      if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_ack: pending %h valid %b expected 00 0", bus.pending, bus.valid);
      end
   endtask

   task automatic test_priority_order();
      logic [2:0] expCode [3];
      logic [7:0] expPend [3];
      expCode = '{3'd7, 3'd4, 3'd1};
      expPend = '{8'h12, 8'h02, 8'h00};
      doReset();
      bus.req = 8'b1001_0010;
      step();
      bus.req = '0;
      step();
      bus.ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         testsRun++;
         if (bus.valid !== 1'b1 || bus.code !== expCode[i]) begin
            testsFailed++;
            $display("[TB] FAIL order_present%0d: valid %b code %0d expected 1 %0d",
                     i, bus.valid, bus.code, expCode[i]);
         end
         step();
         testsRun++;
         if (bus.valid !== 1'b0 || bus.pending !== expPend[i]) begin
            testsFailed++;
            $display("[TB] FAIL order_bubble%0d: valid %b pending %h expected 0 %h",
                     i, bus.valid, bus.pending, expPend[i]);
         end
         step();
      end
      bus.ack = 1'b0;
      testsRun++;
      if (bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL order_drained: valid %b expected 0", bus.valid);
      end
   endtask

   task automatic test_no_preempt();
      doReset();
      bus.req = 8'h08;
      step();
      bus.req = 8'h80;
      step();
      bus.req = '0;
      step();
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd3 || bus.pending !== 8'h88) begin
         testsFailed++;
         $display("[TB] FAIL nopreempt_hold: valid %b code %0d pending %h expected 1 3 88",
                  bus.valid, bus.code, bus.pending);
      end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      testsRun++;
      if (bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL nopreempt_bubble: valid %b expected 0", bus.valid);
      end
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd7) begin
         testsFailed++;
         $display("[TB] FAIL nopreempt_next: valid %b code %0d expected 1 7", bus.valid, bus.code);
      end
      bus.mask = 8'h80;
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd7) begin
         testsFailed++;
         $display("[TB] FAIL mask_no_withdraw: valid %b code %0d expected 1 7", bus.valid, bus.code);
      end
      bus.mask = '0;
   endtask

   task automatic test_mask();
      doReset();
      bus.mask = 8'h80;
      bus.req  = 8'h81;
      step();
      bus.req = '0;
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd0) begin
         testsFailed++;
         $display("[TB] FAIL mask_low: valid %b code %0d expected 1 0", bus.valid, bus.code);
      end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      step();
      step();
      testsRun++;
      if (bus.valid !== 1'b0 || bus.pending !== 8'h80) begin
         testsFailed++;
         $display("[TB] FAIL mask_blocked: valid %b pending %h expected 0 80", bus.valid, bus.pending);
      end
      bus.mask = '0;
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd7) begin
         testsFailed++;
         $display("[TB] FAIL mask_release: valid %b code %0d expected 1 7", bus.valid, bus.code);
      end
   endtask

   task automatic test_overrun();
      doReset();
      bus.req = 8'h20;
      step();
      step();
      bus.req = '0;
      testsRun++;
      if (bus.overrun !== 8'h20 || bus.valid !== 1'b1 || bus.code !== 3'd5) begin
         testsFailed++;
         $display("[TB] FAIL overrun_set: overrun %h valid %b code %0d expected 20 1 5",
                  bus.overrun, bus.valid, bus.code);
      end
      bus.ovr_clr = 1'b1;
      step();
      bus.ovr_clr = 1'b0;
      testsRun++;
      if (bus.overrun !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL overrun_clear: got %h expected 00", bus.overrun);
      end
      bus.req = 8'h02;
      step();
      bus.ovr_clr = 1'b1;
      step();
      bus.req     = '0;
      bus.ovr_clr = 1'b0;
      testsRun++;
      if (bus.overrun !== 8'h02) begin
         testsFailed++;
         $display("[TB] FAIL overrun_beats_clear: got %h expected 02", bus.overrun);
      end
   endtask

   task automatic test_set_wins();
      doReset();
      bus.req = 8'h20;
      step();
      bus.req = '0;
      step();
      bus.ack = 1'b1;
      bus.req = 8'h20;
      step();
      bus.ack = 1'b0;
      bus.req = '0;
      testsRun++;
      if (bus.pending !== 8'h20 || bus.overrun !== 8'h00 || bus.valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL setwins_state: pending %h overrun %h valid %b expected 20 00 0",
                  bus.pending, bus.overrun, bus.valid);
      end
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd5) begin
         testsFailed++;
         $display("[TB] FAIL setwins_represent: valid %b code %0d expected 1 5", bus.valid, bus.code);
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      bus.req = 8'h4C;
      step();
      bus.req = '0;
      step();
      testsRun++;
      if (bus.valid !== 1'b1 || bus.code !== 3'd6 || bus.pending !== 8'h4C) begin
         testsFailed++;
         $display("[TB] FAIL midreset_setup: valid %b code %0d pending %h expected 1 6 4c",
                  bus.valid, bus.code, bus.pending);
      end
      rst     = 1'b1;
      bus.ack = 1'b1;
      step();
      testsRun++;
      if (bus.valid !== 1'b0 || bus.pending !== 8'h00 || bus.code !== 3'd0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_clear: valid %b pending %h code %0d expected 0 00 0",
                  bus.valid, bus.pending, bus.code);
      end
      rst     = 1'b0;
      bus.ack = 1'b0;
      step();
      testsRun++;
      if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL midreset_after: valid %b pending %h expected 0 00", bus.valid, bus.pending);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      test_reset();
      test_single_request();
      test_priority_order();
      test_no_preempt();
      test_mask();
      test_overrun();
      test_set_wins();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
